// File: rtl/vga_pixel_fetch.sv
// Framebuffer fetch stage behind the VGA timing controller: scaled address generation,
// RGB332 -> RGB888 expansion, and sync/blank re-timing matched to the memory latency.
module vga_pixel_fetch #(
    parameter int          FB_W        = 320,
    parameter int          FB_H        = 240,
    parameter int          SCALE_SHIFT = 1,
    parameter int          ADDR_W      = 17,
    parameter int          MEM_LAT     = 2,
    parameter logic [23:0] BORDER_RGB  = 24'h000000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_hs,
    input  logic              i_vs,
    input  logic              i_blank_n,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_rd_en,
    input  logic [7:0]        i_rdata,
    output logic [7:0]        o_r,
    output logic [7:0]        o_g,
    output logic [7:0]        o_b,
    output logic              o_hs,
    output logic              o_vs,
    output logic              o_blank_n,
    output logic              o_frame_start,
    output logic              o_locked
);

    localparam int                L           = MEM_LAT + 1;
    localparam logic [9:0]        C_FB_W      = 10'(FB_W);
    localparam logic [9:0]        C_FB_H      = 10'(FB_H);
    localparam logic [10:0]       C_FB_H11    = 11'(FB_H);
    localparam logic [10:0]       C_ROW_MASK  = 11'((1 << SCALE_SHIFT) - 1);
    localparam logic [ADDR_W-1:0] C_LINE_STEP = ADDR_W'(FB_W);

    logic [9:0]        r_col;
    logic [9:0]        r_row;
    logic [ADDR_W-1:0] r_line_base;
    logic              r_blank_d;
    logic              r_vs_d;
    logic              r_locked;
    logic              r_frame_start;
    logic [L-1:0]      r_hs_pipe;
    logic [L-1:0]      r_vs_pipe;
    logic [L-1:0]      r_blank_pipe;
    logic [MEM_LAT-1:0] r_rd_pipe;
    logic [MEM_LAT-1:0] r_win_pipe;
    logic [23:0]       r_rgb;

    logic              w_blank_fall;
    logic [10:0]       w_row_p1;
    logic              w_line_step;
    logic [9:0]        w_col_fb;
    logic [9:0]        w_row_fb;
    logic              w_in_win;
    logic              w_rd_en;
    logic [23:0]       w_expand;

    always_comb begin
        w_blank_fall = r_blank_d & ~i_blank_n;
        w_row_p1     = {1'b0, r_row} + 11'd1;
        w_line_step  = ((w_row_p1 & C_ROW_MASK) == 11'd0) &&
                       ((w_row_p1 >> SCALE_SHIFT) < C_FB_H11);
        w_col_fb     = r_col >> SCALE_SHIFT;
        w_row_fb     = r_row >> SCALE_SHIFT;
        w_in_win     = (w_col_fb < C_FB_W) && (w_row_fb < C_FB_H);
        w_rd_en      = i_blank_n & w_in_win & r_locked;
        w_expand     = {i_rdata[7:5], i_rdata[7:5], i_rdata[7:6],
                        i_rdata[4:2], i_rdata[4:2], i_rdata[4:3],
                        {4{i_rdata[1:0]}}};
    end

    // Position tracking; an active vsync overrides a coincident end-of-line edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_col       <= '0;
            r_row       <= '0;
            r_line_base <= '0;
            r_blank_d   <= 1'b0;
        end else begin
            r_blank_d <= i_blank_n;
            if (!i_blank_n)
                r_col <= '0;
            else if (r_col != '1)
                r_col <= r_col + 10'd1;
            if (!i_vs) begin
                r_row       <= '0;
                r_line_base <= '0;
            end else if (w_blank_fall) begin
                if (r_row != '1)
                    r_row <= r_row + 10'd1;
                if (w_line_step)
                    r_line_base <= r_line_base + C_LINE_STEP;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vs_d        <= 1'b0;
            r_locked      <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_vs_d        <= i_vs;
            r_locked      <= r_locked | ~i_vs;
            r_frame_start <= r_vs_d & ~i_vs;
        end
    end

    // Colour is registered as i_rdata arrives, so it lands on the last sync stage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hs_pipe    <= '0;
            r_vs_pipe    <= '0;
            r_blank_pipe <= '0;
            r_rd_pipe    <= '0;
            r_win_pipe   <= '0;
            r_rgb        <= '0;
        end else begin
            r_hs_pipe    <= L'({r_hs_pipe, i_hs});
            r_vs_pipe    <= L'({r_vs_pipe, i_vs});
            r_blank_pipe <= L'({r_blank_pipe, i_blank_n});
            r_rd_pipe    <= MEM_LAT'({r_rd_pipe, w_rd_en});
            r_win_pipe   <= MEM_LAT'({r_win_pipe, w_in_win});
            if (!r_blank_pipe[MEM_LAT-1])
                r_rgb <= '0;
            else if (r_rd_pipe[MEM_LAT-1] && r_win_pipe[MEM_LAT-1])
                r_rgb <= w_expand;
            else
                r_rgb <= BORDER_RGB;
        end
    end

    assign o_rd_en       = w_rd_en;
    assign o_addr        = w_rd_en ? (r_line_base + ADDR_W'(w_col_fb)) : '0;
    assign o_r           = r_rgb[23:16];
    assign o_g           = r_rgb[15:8];
    assign o_b           = r_rgb[7:0];
    assign o_hs          = r_hs_pipe[L-1];
    assign o_vs          = r_vs_pipe[L-1];
    assign o_blank_n     = r_blank_pipe[L-1];
    assign o_frame_start = r_frame_start;
    assign o_locked      = r_locked;

endmodule
